// File: rtl/whack_game_engine_if.sv
// Signal bundle between the game engine, its tick/mode/switch sources and the
// score/timer display path.
interface whack_game_engine_if #(
    parameter int NUM_HOLES = 16,
    parameter int SCORE_W   = 14
);
    logic                 tick_i;
    logic                 start_i;
    logic [1:0]           mode_i;
    logic [NUM_HOLES-1:0] switches_i;
    logic [NUM_HOLES-1:0] moles_o;
    logic [1:0]           state_o;
    logic [7:0]           time_left_o;
    logic [SCORE_W-1:0]   score_o;
    logic [SCORE_W-1:0]   misses_o;

    modport master (
        output tick_i, start_i, mode_i, switches_i,
        input  moles_o, state_o, time_left_o, score_o, misses_o
    );

    modport slave (
        input  tick_i, start_i, mode_i, switches_i,
        output moles_o, state_o, time_left_o, score_o, misses_o
    );
endinterface

// File: rtl/whack_game_engine.sv
// Single-clock whack-a-mole engine: countdown, timed play with several moles,
// per-mole lifetimes, hit/penalty scoring and miss counting, all on tick_i.
module whack_game_engine #(
    parameter int NUM_HOLES         = 16,
    parameter int MAX_ACTIVE        = 2,
    parameter int GAME_SECONDS      = 30,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int SCORE_W           = 14
) (
    input  logic                clock_i,
    input  logic                reset_i,
    whack_game_engine_if.slave  bus
);
    localparam int HOLE_W = $clog2(NUM_HOLES);
    localparam logic [HOLE_W:0]    MAX_ACT   = MAX_ACTIVE[HOLE_W:0];
    localparam logic [7:0]         GAME_T    = GAME_SECONDS[7:0];
    localparam logic [7:0]         CD_T      = COUNTDOWN_SECONDS[7:0];
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sub_q, sub_d;
    logic [7:0]           time_q, time_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   miss_q, miss_d;
    logic [NUM_HOLES-1:0] moles_q, moles_d;
    logic [3:0]           life_q [NUM_HOLES];
    logic [3:0]           life_d [NUM_HOLES];
    logic [1:0]           mode_q, mode_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NUM_HOLES-1:0] sync1_q, sync1_d;
    logic [NUM_HOLES-1:0] sync2_q, sync2_d;
    logic [NUM_HOLES-1:0] prev_q, prev_d;

    logic [NUM_HOLES-1:0] rise;
    logic [NUM_HOLES-1:0] hit;
    logic [NUM_HOLES-1:0] expired;
    logic                 wrong_any;
    logic                 second;
    logic [HOLE_W-1:0]    cand;

    function automatic logic [3:0] life_of(input logic [1:0] m);
        case (m)
            2'd1:    return 4'd8;
            2'd2:    return 4'd4;
            2'd3:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [HOLE_W:0] count_ones(input logic [NUM_HOLES-1:0] v);
        logic [HOLE_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            n = n + {{HOLE_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Saturating add of a small count, with an optional single-step decrement floored at 0.
    function automatic logic [SCORE_W-1:0] sat_update(input logic [SCORE_W-1:0] base,
                                                     input logic [HOLE_W:0]    inc,
                                                     input logic               dec);
        logic [SCORE_W+1:0] sum;
        sum = {2'b00, base} + {{(SCORE_W+1-HOLE_W){1'b0}}, inc};
        if (dec && (sum != '0)) begin
            sum = sum - {{(SCORE_W+1){1'b0}}, 1'b1};
        end
        if (sum > {2'b00, SCORE_MAX}) begin
            return SCORE_MAX;
        end
        return sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        time_d  = time_q;
        score_d = score_q;
        miss_d  = miss_q;
        moles_d = moles_q;
        life_d  = life_q;
        mode_d  = mode_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sync1_d = bus.switches_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        rise      = sync2_q & ~prev_q;
        hit       = rise & moles_q;
        wrong_any = |(rise & ~moles_q);
        expired   = '0;
        second    = bus.tick_i && (sub_q == 2'd3);
        cand      = lfsr_q[HOLE_W-1:0];

        if (bus.tick_i) begin
            sub_d = sub_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start_i && (bus.mode_i != 2'd0)) begin
                    state_d = S_COUNTDOWN;
                    mode_d  = bus.mode_i;
                    time_d  = CD_T;
                    score_d = '0;
                    miss_d  = '0;
                    sub_d   = 2'd0;
                end
            end
            S_COUNTDOWN: begin
                if (second) begin
                    if (time_q == 8'd1) begin
                        state_d = S_PLAY;
                        time_d  = GAME_T;
                        moles_d = '0;
                        sub_d   = 2'd0;
                        for (int h = 0; h < NUM_HOLES; h++) life_d[h] = 4'd0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // Whacks still score on the final second; moles left lit are simply dropped.
                score_d = sat_update(score_q, count_ones(hit), wrong_any);
                if (second && (time_q == 8'd1)) begin
                    state_d = S_OVER;
                    time_d  = 8'd0;
                    moles_d = '0;
                    sub_d   = 2'd0;
                    for (int h = 0; h < NUM_HOLES; h++) life_d[h] = 4'd0;
                end else begin
                    if (second) begin
                        time_d = time_q - 8'd1;
                    end
                    for (int h = 0; h < NUM_HOLES; h++) begin
                        if (hit[h]) begin
                            moles_d[h] = 1'b0;
                            life_d[h]  = 4'd0;
                        end else if (moles_q[h] && bus.tick_i) begin
                            life_d[h] = life_q[h] - 4'd1;
                            if (life_q[h] == 4'd1) begin
                                moles_d[h] = 1'b0;
                                expired[h] = 1'b1;
                            end
                        end
                    end
                    // A candidate that is lit (including one being hit) never spawns.
                    if (bus.tick_i && (count_ones(moles_q) < MAX_ACT) && !moles_q[cand]) begin
                        moles_d[cand] = 1'b1;
                        life_d[cand]  = life_of(mode_q);
                    end
                    miss_d = sat_update(miss_q, count_ones(expired), 1'b0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            sub_q   <= 2'd0;
            time_q  <= 8'd0;
            score_q <= '0;
            miss_q  <= '0;
            moles_q <= '0;
            for (int h = 0; h < NUM_HOLES; h++) life_q[h] <= 4'd0;
            mode_q  <= 2'd0;
            lfsr_q  <= 16'hACE1;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            time_q  <= time_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            moles_q <= moles_d;
            life_q  <= life_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign bus.moles_o     = moles_q;
    assign bus.state_o     = state_q;
    assign bus.time_left_o = time_q;
    assign bus.score_o     = score_q;
    assign bus.misses_o    = miss_q;
endmodule
